// File: rtl/fp_div_ctrl.sv
// Sequencing controller for a bfloat16 divider: special-operand bypass, divider handshake, sticky flags.
// Optional watchdog on the divider response is enabled by defining FP_DIV_CTRL_TIMEOUT_EN.
module fp_div_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        div_start,
  output logic [15:0] div_opA,
  output logic [15:0] div_opB,
  input  logic [15:0] div_quotient,
  input  logic        div_underflow,
  input  logic        div_overflow,
  input  logic        div_inexact,
  input  logic        div_valid,
  input  logic        div_busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [4:0]  out_flags,
  output logic [4:0]  sticky_flags,
  input  logic        flag_clear
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] QNAN = 16'h7FC0;

  state_t      state, state_next;
  logic [15:0] result_next;
  logic [4:0]  flags_next;
  logic        first_wait;
  logic        timeout_hit;

  // The divider's busy signal carries no information the controller needs.
  logic unused_ok;
  assign unused_ok = div_busy | (TIMEOUT == 0);

  // Operand classification; exponent zero flushes subnormals to a signed zero.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, q_sign;
  logic special;
  logic [15:0] byp_result;
  logic [4:0]  byp_flags;

  always_comb begin
    a_zero = (in_a[14:7] == 8'h00);
    b_zero = (in_b[14:7] == 8'h00);
    a_inf  = (in_a[14:7] == 8'hFF) && (in_a[6:0] == 7'h00);
    b_inf  = (in_b[14:7] == 8'hFF) && (in_b[6:0] == 7'h00);
    a_nan  = (in_a[14:7] == 8'hFF) && (in_a[6:0] != 7'h00);
    b_nan  = (in_b[14:7] == 8'hFF) && (in_b[6:0] != 7'h00);
    q_sign = in_a[15] ^ in_b[15];
    special    = 1'b1;
    byp_result = 16'h0000;
    byp_flags  = 5'b00000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      byp_result = QNAN;
      byp_flags  = 5'b10000;
    end else if (a_inf) begin
      byp_result = {q_sign, 8'hFF, 7'h00};
    end else if (b_zero) begin
      byp_result = {q_sign, 8'hFF, 7'h00};
      byp_flags  = 5'b01000;
    end else if (a_zero || b_inf) begin
      byp_result = {q_sign, 15'h0000};
    end else begin
      special = 1'b0;
    end
  end

`ifdef FP_DIV_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th WAIT cycle, so DONE follows exactly TIMEOUT WAIT cycles.
  assign timeout_hit = (state == WAIT) && (wd_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    result_next = out_result;
    flags_next  = out_flags;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (special) begin
            state_next  = DONE;
            result_next = byp_result;
            flags_next  = byp_flags;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (div_valid && !first_wait) begin
          state_next  = DONE;
          result_next = div_quotient;
          flags_next  = {2'b00, div_overflow, div_underflow, div_inexact};
        end else if (timeout_hit) begin
          state_next  = DONE;
          result_next = QNAN;
          flags_next  = 5'b10000;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      first_wait   <= 1'b0;
      div_opA      <= 16'h0000;
      div_opB      <= 16'h0000;
      out_result   <= 16'h0000;
      out_flags    <= 5'b00000;
      sticky_flags <= 5'b00000;
    end else begin
      state      <= state_next;
      out_result <= result_next;
      out_flags  <= flags_next;
      first_wait <= (state == ISSUE);
      if (state == IDLE && in_valid) begin
        div_opA <= in_a;
        div_opB <= in_b;
      end
      // A clear coinciding with a handshake keeps only the flags being delivered now.
      if (out_valid && out_ready) begin
        sticky_flags <= flag_clear ? out_flags : (sticky_flags | out_flags);
      end else if (flag_clear) begin
        sticky_flags <= 5'b00000;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign div_start = (state == ISSUE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_div_ctrl.sv
// Directed vector bench for fp_div_ctrl with a latency-programmable divider model.
// Watchdog sequence is compiled only when FP_DIV_CTRL_TIMEOUT_EN is defined.
module tb_fp_div_ctrl;

  localparam int TB_TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        div_start;
  logic [15:0] div_opA, div_opB;
  logic [15:0] div_quotient;
  logic        div_underflow, div_overflow, div_inexact;
  logic        div_valid;
  logic        div_busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [4:0]  out_flags;
  logic [4:0]  sticky_flags;
  logic        flag_clear = 1'b0;

  fp_div_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_start(div_start), .div_opA(div_opA), .div_opB(div_opB),
    .div_quotient(div_quotient), .div_underflow(div_underflow),
    .div_overflow(div_overflow), .div_inexact(div_inexact),
    .div_valid(div_valid), .div_busy(div_busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .flag_clear(flag_clear)
  );

  always #5 clk = ~clk;

  // Divider model: answers model_lat edges after div_start (0 = never), or holds valid high when stuck.
  int          model_lat = 0;
  logic [15:0] model_q = 16'h0;
  logic [2:0]  model_fl = 3'b000;   // {overflow, underflow, inexact}
  logic        stuck = 1'b0;
  int          rem;
  int          n_start = 0;
  logic [15:0] seen_a, seen_b;

  assign div_quotient  = model_q;
  assign div_overflow  = model_fl[2];
  assign div_underflow = model_fl[1];
  assign div_inexact   = model_fl[0];
  assign div_busy      = (rem != 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem       <= 0;
      div_valid <= 1'b0;
    end else begin
      if (div_start) begin
        n_start <= n_start + 1;
        seen_a  <= div_opA;
        seen_b  <= div_opB;
      end
      if (stuck) begin
        div_valid <= 1'b1;
      end else if (div_start) begin
        rem       <= model_lat;
        div_valid <= 1'b0;
      end else if (rem == 1) begin
        rem       <= 0;
        div_valid <= 1'b1;
      end else begin
        if (rem > 1) rem <= rem - 1;
        div_valid <= 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_op", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges after the accepting edge until out_valid is seen.
  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
    check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic handshake(input logic clr);
    out_ready  = 1'b1;
    flag_clear = clr;
    @(posedge clk);
    #1;
    out_ready  = 1'b0;
    flag_clear = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b, q;
    logic [2:0]  dfl;
    int          lat;
    logic [15:0] exp_res;
    logic [4:0]  exp_flags;
    int          exp_cyc;
    int          exp_starts;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cyc, base;
    logic [4:0]  exp_sticky;
    logic [15:0] held;

    vecs[0]  = '{16'h4000, 16'h3F80, 16'h4000, 3'b000, 10, 16'h4000, 5'b00000, 13, 1};
    vecs[1]  = '{16'h3F80, 16'h0000, 16'h0000, 3'b000, 10, 16'h7F80, 5'b01000, 1, 0};
    vecs[2]  = '{16'h7FC1, 16'h3F80, 16'h0000, 3'b000, 10, 16'h7FC0, 5'b10000, 1, 0};
    vecs[3]  = '{16'h0000, 16'h8000, 16'h0000, 3'b000, 10, 16'h7FC0, 5'b10000, 1, 0};
    vecs[4]  = '{16'hBF80, 16'h0000, 16'h0000, 3'b000, 10, 16'hFF80, 5'b01000, 1, 0};
    vecs[5]  = '{16'h7F80, 16'h7F80, 16'h0000, 3'b000, 10, 16'h7FC0, 5'b10000, 1, 0};
    vecs[6]  = '{16'h0000, 16'hC000, 16'h0000, 3'b000, 10, 16'h8000, 5'b00000, 1, 0};
    vecs[7]  = '{16'h4000, 16'hFF80, 16'h0000, 3'b000, 10, 16'h8000, 5'b00000, 1, 0};
    vecs[8]  = '{16'hFF80, 16'h4000, 16'h0000, 3'b000, 10, 16'hFF80, 5'b00000, 1, 0};
    vecs[9]  = '{16'h8005, 16'h3F80, 16'h0000, 3'b000, 10, 16'h8000, 5'b00000, 1, 0};
    vecs[10] = '{16'h3F80, 16'h7F81, 16'h0000, 3'b000, 10, 16'h7FC0, 5'b10000, 1, 0};
    vecs[11] = '{16'hC040, 16'h3F80, 16'hC040, 3'b011, 3,  16'hC040, 5'b00011, 6, 1};

    // Reset state
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_div_start", {31'b0, div_start}, 32'd0);
    check("rst_out_result", {16'b0, out_result}, 32'h0);
    check("rst_out_flags", {27'b0, out_flags}, 32'h0);
    check("rst_sticky", {27'b0, sticky_flags}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    exp_sticky = 5'b00000;
    for (int i = 0; i < 12; i++) begin
      model_q   = vecs[i].q;
      model_fl  = vecs[i].dfl;
      model_lat = vecs[i].lat;
      base      = n_start;
      start_op(vecs[i].a, vecs[i].b);
      wait_out(cyc);
      $display("op %0d a=%h b=%h result=%h flags=%b cycles=%0d", i, vecs[i].a, vecs[i].b,
               out_result, out_flags, cyc);
      check("vec_result", {16'b0, out_result}, {16'b0, vecs[i].exp_res});
      check("vec_flags", {27'b0, out_flags}, {27'b0, vecs[i].exp_flags});
      check("vec_latency", cyc, vecs[i].exp_cyc);
      handshake(1'b0);
      exp_sticky = exp_sticky | vecs[i].exp_flags;
      @(negedge clk);
      check("vec_starts", n_start - base, vecs[i].exp_starts);
      check("vec_sticky", {27'b0, sticky_flags}, {27'b0, exp_sticky});
      if (vecs[i].exp_starts == 1) begin
        check("vec_opA", {16'b0, seen_a}, {16'b0, vecs[i].a});
        check("vec_opB", {16'b0, seen_b}, {16'b0, vecs[i].b});
      end
    end

    // flag_clear alone empties the sticky register
    flag_clear = 1'b1;
    @(posedge clk);
    #1 flag_clear = 1'b0;
    @(negedge clk);
    $display("flag_clear alone sticky=%b", sticky_flags);
    check("clear_alone", {27'b0, sticky_flags}, 32'h0);

    // Back-pressure: result held stable while out_ready stays low
    start_op(16'h3F80, 16'h0000);
    wait_out(cyc);
    held = out_result;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_result", {16'b0, out_result}, 32'h7F80);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    $display("backpressure held result=%h flags=%b", held, out_flags);
    handshake(1'b0);
    start_op(16'h7FC1, 16'h3F80);
    wait_out(cyc);
    handshake(1'b0);
    @(negedge clk);
    $display("sticky after dbz+invalid=%b", sticky_flags);
    check("sticky_or", {27'b0, sticky_flags}, 32'h18);

    // Clear coinciding with handshake keeps only the new flags
    model_q = 16'h7F80; model_fl = 3'b101; model_lat = 4;
    start_op(16'h7E00, 16'h0080);
    wait_out(cyc);
    check("ovf_flags", {27'b0, out_flags}, 32'h05);
    handshake(1'b1);
    @(negedge clk);
    $display("clear+handshake sticky=%b", sticky_flags);
    check("clear_with_hs", {27'b0, sticky_flags}, 32'h05);

    // div_valid already high in the first WAIT cycle must be ignored
    model_q = 16'h3F80; model_fl = 3'b000; stuck = 1'b1;
    start_op(16'h4000, 16'h4000);
    wait_out(cyc);
    $display("early valid result=%h cycles=%0d", out_result, cyc);
    check("early_valid_latency", cyc, 4);
    check("early_valid_result", {16'b0, out_result}, 32'h3F80);
    stuck = 1'b0;
    handshake(1'b0);

`ifdef FP_DIV_CTRL_TIMEOUT_EN
    model_lat = 0;
    start_op(16'h4000, 16'h3F80);
    wait_out(cyc);
    $display("timeout result=%h flags=%b cycles=%0d", out_result, out_flags, cyc);
    check("timeout_result", {16'b0, out_result}, 32'h7FC0);
    check("timeout_flags", {27'b0, out_flags}, 32'h10);
    check("timeout_latency", cyc, TB_TIMEOUT + 2);
    handshake(1'b0);
`endif

    // Reset during WAIT aborts; later div_valid in IDLE is ignored
    model_lat = 0;
    start_op(16'h4000, 16'h3F80);
    repeat (4) @(negedge clk);
    check("mid_in_ready", {31'b0, in_ready}, 32'd0);
    reset_n = 1'b0;
    #2;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_sticky", {27'b0, sticky_flags}, 32'h0);
    check("arst_result", {16'b0, out_result}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    stuck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_out", {31'b0, out_valid}, 32'd0);
      check("post_rst_idle", {31'b0, in_ready}, 32'd1);
      check("post_rst_no_start", {31'b0, div_start}, 32'd0);
    end
    stuck = 1'b0;
    $display("reset abort out_valid=%b in_ready=%b", out_valid, in_ready);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fp_div_ctrl.md
FP_DIV_CTRL -- requirements
Module: fp_div_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have: in_valid in 1, in_ready out 1, in_a in 16, in_b in 16 (bfloat16 dividend, divisor: sign[15], exp[14:7], man[6:0]).
REQ-003 SHALL have divider-side ports: div_start out 1, div_opA out 16, div_opB out 16, div_quotient in 16, div_underflow in 1, div_overflow in 1, div_inexact in 1, div_valid in 1, div_busy in 1.
REQ-004 SHALL have: out_valid out 1, out_ready in 1, out_result out 16, out_flags out 5 ({invalid, dbz, overflow, underflow, inexact}).
REQ-005 SHALL have: sticky_flags out 5 (accumulated out_flags), flag_clear in 1.
REQ-006 SHALL have parameter TIMEOUT, default 32, meaning the divider watchdog limit in cycles.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; in_ready = (state == IDLE).
REQ-008 IDLE: on in_valid, capture in_a/in_b; special case -> DONE with bypass result; else -> ISSUE.
REQ-009 Operand classes: exp==0 is zero (subnormals flushed, sign kept); exp==FF, man==0 is inf; exp==FF, man!=0 is NaN.
REQ-010 Bypass: any NaN, 0/0 or inf/inf -> 16'h7FC0, invalid=1; finite nonzero/0 -> signed inf, dbz=1; 0/finite or finite/inf -> signed zero; inf/finite -> signed inf; sign = sA^sB except NaN.
REQ-011 Bypass latency: accept in cycle N -> out_valid in cycle N+1.
REQ-012 ISSUE: div_start=1 for exactly one cycle with div_opA/div_opB = captured operands (held stable until DONE); -> WAIT.
REQ-013 WAIT: div_valid SHALL be ignored on the first WAIT cycle; on any later cycle with div_valid=1, capture div_quotient and {0,0,div_overflow,div_underflow,div_inexact}; -> DONE.
REQ-014 DONE: out_valid=1, out_result/out_flags stable; on out_ready -> IDLE; a new input is not accepted in the same cycle.
REQ-015 div_start SHALL be 0 in every state except ISSUE.
REQ-016 On handshake (out_valid & out_ready): sticky_flags <= sticky_flags | out_flags; on flag_clear alone: sticky_flags <= 0; both in the same cycle: sticky_flags <= out_flags.
REQ-017 Watchdog counter SHALL be cleared on entry to WAIT and increment each WAIT cycle.

Reset
REQ-018 reset_n low SHALL asynchronously force state=IDLE, in_ready=1 after release, div_start=0, out_valid=0, out_result=0, out_flags=0, sticky_flags=0, counter=0.
REQ-019 Reset mid-operation (ISSUE/WAIT/DONE) SHALL abort the operation with no result delivered; div_valid pulses arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-020 Macro FP_DIV_CTRL_TIMEOUT_EN: defined -> when the watchdog counter reaches TIMEOUT in WAIT, go to DONE with out_result=16'h7FC0, out_flags=invalid only.
REQ-021 Without FP_DIV_CTRL_TIMEOUT_EN: no counter logic; WAIT holds indefinitely until div_valid.

Verification
REQ-022 in_a=16'h4000 (2.0), in_b=16'h3F80 (1.0), divider model returns 16'h4000 after 10 cycles -> one div_start pulse, out_result=16'h4000, out_flags=0.
REQ-023 in_a=16'h3F80, in_b=16'h0000 -> no div_start, out_valid next cycle, out_result=16'h7F80, out_flags=5'b01000.
REQ-024 in_a=16'h7FC1, in_b=16'h3F80 and in_a=16'h0000, in_b=16'h8000 -> out_result=16'h7FC0, invalid=1 both cases.
REQ-025 Hold out_ready=0 for 5 cycles after out_valid -> out_result stable, in_ready=0; then both operations' flags OR into sticky_flags; flag_clear with simultaneous handshake -> sticky_flags equals new out_flags only.
REQ-026 With FP_DIV_CTRL_TIMEOUT_EN, divider never asserts div_valid -> after TIMEOUT WAIT cycles out_result=16'h7FC0, invalid=1; reset_n pulse during WAIT -> IDLE, out_valid=0.
